// File: rtl/key_pkg.sv
// Shared definitions for the front-panel key conditioning slice.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int KEY_N        = 3;
  localparam int DEBOUNCE_DEF = 2_000_000;   // 20 ms at 100 MHz
  localparam int LONG_DEF     = 100_000_000; // 1 s at 100 MHz

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and long-press timer.
//
// state        | meaning
// IDLE         | key released, waiting for a raw press
// PRESS_WAIT   | raw press seen, counting stable pressed samples
// PRESSED      | press accepted, long-press timer running
// RELEASE_WAIT | raw release seen, counting stable released samples
module key_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = LONG_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  logic          sync1, sync2;
  key_state_t    state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          fired, fired_nxt;
  logic          level_nxt, press_nxt, long_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= IDLE;
      dcnt      <= '0;
      lcnt      <= '0;
      fired     <= 1'b0;
      key_level <= 1'b0;
      key_press <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      sync1     <= key_in;
      sync2     <= sync1;
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      lcnt      <= lcnt_nxt;
      fired     <= fired_nxt;
      key_level <= level_nxt;
      key_press <= press_nxt;
      key_long  <= long_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    lcnt_nxt  = lcnt;
    fired_nxt = fired;
    level_nxt = key_level;
    press_nxt = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = PRESS_WAIT;
          dcnt_nxt  = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_nxt = IDLE;
        end else if (dcnt == D_LAST) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          lcnt_nxt  = '0;
          fired_nxt = 1'b0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nxt = RELEASE_WAIT;
          dcnt_nxt  = DW'(1);
        end else if (!fired) begin
          // lcnt parks at its last value once the long pulse has fired
          if (lcnt == L_LAST) begin
            long_nxt  = 1'b1;
            fired_nxt = 1'b1;
          end else begin
            lcnt_nxt = lcnt + LW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // bounce back to PRESSED keeps lcnt/fired so the long timer resumes
        if (sync2) begin
          state_nxt = PRESSED;
        end else if (dcnt == D_LAST) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/key_cond.sv
// Front-panel button conditioning: KEY_N independent debounced channels.
module key_cond
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = LONG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_N-1:0] key_in,
  output logic [KEY_N-1:0] key_level,
  output logic [KEY_N-1:0] key_press,
  output logic [KEY_N-1:0] key_long
);

  for (genvar i = 0; i < KEY_N; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in[i]),
      .key_level(key_level[i]),
      .key_press(key_press[i]),
      .key_long (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond: pulse scoreboard plus level checks.
module tb_key_cond;
  import key_pkg::*;

  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_in = 3'b000;
  logic [2:0] key_level, key_press, key_long;

  int edge_n = 0;
  int total  = 0;
  int bad    = 0;
  int e;

  typedef struct {int cyc; int kind; int ch;} evt_t;
  evt_t exp_q[$];

  key_cond #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_long (key_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int key_of(input evt_t ev);
    return ev.cyc * 16 + ev.kind * 4 + ev.ch;
  endfunction

  // kind 0 = key_press, kind 1 = key_long; cyc = edge after which it is high
  task automatic expect_evt(input int cyc, input int kind, input int ch);
    evt_t ev;
    int   pos;
    ev.cyc = cyc; ev.kind = kind; ev.ch = ch;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (key_of(exp_q[i]) > key_of(ev)) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, ev);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        chk("missed_pulse_edge", edge_n, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      for (int kind = 0; kind < 2; kind++) begin
        for (int ch = 0; ch < 3; ch++) begin
          logic b;
          b = (kind == 0) ? key_press[ch] : key_long[ch];
          if (b) begin
            if (exp_q.size() == 0 || exp_q[0].cyc > edge_n) begin
              chk("spurious_pulse", edge_n * 16 + kind * 4 + ch, -1);
            end else begin
              chk("pulse", edge_n * 16 + kind * 4 + ch, key_of(exp_q[0]));
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_level", key_level, 0);
    chk("rst_press", key_press, 0);
    chk("rst_long",  key_long,  0);
    step(3);
    rst = 1'b0;
    step(2);

    // clean press, long pulse, then release glitch on channel 0
    e = edge_n;
    key_in[0] = 1'b1;
    expect_evt(e + D + 2, 0, 0);
    expect_evt(e + D + 2 + L, 1, 0);
    step(D + 1);
    chk("c0_level_before", key_level[0], 0);
    step(1);
    chk("c0_level_accept", key_level[0], 1);
    step(L + 2);
    key_in[0] = 1'b0;
    step(2);
    key_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("c0_glitch_level", key_level[0], 1);
    end
    e = edge_n;
    key_in[0] = 1'b0;
    step(D + 1);
    chk("c0_rel_level_hold", key_level[0], 1);
    step(1);
    chk("c0_rel_level_low", key_level[0], 0);
    step(3);
    chk("q_empty_c0", exp_q.size(), 0);

    // bounce rejection on channel 1
    for (int i = 0; i < 2; i++) begin
      key_in[1] = 1'b1;
      step(2);
      chk("c1_bounce_hi", key_level[1], 0);
      key_in[1] = 1'b0;
      step(2);
      chk("c1_bounce_lo", key_level[1], 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("c1_bounce_idle", key_level[1], 0);
    end
    chk("q_empty_c1", exp_q.size(), 0);

    // long press on channel 2, held 30 cycles
    e = edge_n;
    key_in[2] = 1'b1;
    expect_evt(e + D + 2, 0, 2);
    expect_evt(e + D + 2 + L, 1, 2);
    step(30);
    key_in[2] = 1'b0;
    step(D + 1);
    chk("c2_rel_level_hold", key_level[2], 1);
    step(1);
    chk("c2_rel_level_low", key_level[2], 0);
    step(3);
    chk("q_empty_c2", exp_q.size(), 0);

    // simultaneous press on all channels
    e = edge_n;
    key_in = 3'b111;
    for (int ch = 0; ch < 3; ch++) begin
      expect_evt(e + D + 2, 0, ch);
      expect_evt(e + D + 2 + L, 1, ch);
    end
    step(D + 2);
    chk("all_level_high", key_level, 7);
    step(L + 4);
    key_in = 3'b000;
    step(D + 2);
    chk("all_level_low", key_level, 0);
    step(2);
    chk("q_empty_all", exp_q.size(), 0);

    // reset during PRESS_WAIT of channel 0
    e = edge_n;
    key_in[0] = 1'b1;
    expect_evt(e + D + 2, 0, 0);
    step(4);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rstpw_level", key_level, 0);
    chk("rstpw_press", key_press, 0);
    step(2);
    rst = 1'b0;
    e = edge_n;
    expect_evt(e + D + 2, 0, 0);
    expect_evt(e + D + 2 + L, 1, 0);
    step(D + 1);
    chk("rstpw_relevel_before", key_level[0], 0);
    step(1);
    chk("rstpw_relevel_accept", key_level[0], 1);
    step(L + 2);
    key_in[0] = 1'b0;
    step(D + 3);
    chk("q_empty_rstpw", exp_q.size(), 0);

    // reset during PRESSED of channel 1
    e = edge_n;
    key_in[1] = 1'b1;
    expect_evt(e + D + 2, 0, 1);
    expect_evt(e + D + 2 + L, 1, 1);
    step(D + 5);
    chk("rstpr_level_pre", key_level[1], 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rstpr_level", key_level, 0);
    chk("rstpr_long",  key_long,  0);
    step(2);
    rst = 1'b0;
    e = edge_n;
    expect_evt(e + D + 2, 0, 1);
    expect_evt(e + D + 2 + L, 1, 1);
    step(D + 1);
    chk("rstpr_relevel_before", key_level[1], 0);
    step(1);
    chk("rstpr_relevel_accept", key_level[1], 1);
    step(L + 2);
    key_in[1] = 1'b0;
    step(D + 3);
    chk("rstpr_level_final", key_level, 0);
    chk("q_empty_rstpr", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
